// File: rtl/decoder_scan_seq.sv
// rtl/decoder_scan_seq.sv - row-scan sequencer driving a 3-to-8 decoder (select + enables)
// Optional inter-row blanking is compiled in by defining BLANKING_EN.
module decoder_scan_seq #(
  parameter int DWELL_CYCLES = 4,
  parameter int BLANK_CYCLES = 1
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic       continuous_i,
  output logic       select_a_o,
  output logic       select_b_o,
  output logic       select_c_o,
  output logic       g1_en_o,
  output logic       g2a_en_n_o,
  output logic       g2b_en_n_o,
  output logic [2:0] row_idx_o,
  output logic       busy_o,
  output logic       scan_done_o
);

  localparam logic [7:0] DWELL_LAST = 8'(DWELL_CYCLES - 1);
`ifdef BLANKING_EN
  localparam logic [7:0] BLANK_LAST = 8'(BLANK_CYCLES - 1);
`endif

  if (DWELL_CYCLES < 1 || DWELL_CYCLES > 255 || BLANK_CYCLES < 1 || BLANK_CYCLES > 255) begin : g_param_check
    $error("decoder_scan_seq: DWELL_CYCLES and BLANK_CYCLES must be within 1..255");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1
`ifdef BLANKING_EN
    , BLANK = 2'd2
`endif
  } state_e;

  state_e     state_q;
  logic [2:0] row_q;
  logic [7:0] dwell_q;
`ifdef BLANKING_EN
  logic [7:0] blank_q;
`endif
  logic       en_q;
  logic       busy_q;
  logic       done_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      row_q   <= 3'd0;
      dwell_q <= 8'd0;
`ifdef BLANKING_EN
      blank_q <= 8'd0;
`endif
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i && !stop_i) begin
            state_q <= DRIVE;
            row_q   <= 3'd0;
            dwell_q <= 8'd0;
            en_q    <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        DRIVE: begin
          // stop wins over row completion, so no done pulse on an aborted sweep
          if (stop_i) begin
            state_q <= IDLE;
            row_q   <= 3'd0;
            dwell_q <= 8'd0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
          end else if (dwell_q == DWELL_LAST) begin
            dwell_q <= 8'd0;
            if (row_q == 3'd7) begin
              done_q <= 1'b1;
              if (continuous_i) begin
`ifdef BLANKING_EN
                state_q <= BLANK;
                blank_q <= 8'd0;
                en_q    <= 1'b0;
`else
                row_q   <= 3'd0;
`endif
              end else begin
                state_q <= IDLE;
                row_q   <= 3'd0;
                en_q    <= 1'b0;
                busy_q  <= 1'b0;
              end
            end else begin
`ifdef BLANKING_EN
              state_q <= BLANK;
              blank_q <= 8'd0;
              en_q    <= 1'b0;
`else
              row_q   <= row_q + 3'd1;
`endif
            end
          end else begin
            dwell_q <= dwell_q + 8'd1;
          end
        end
`ifdef BLANKING_EN
        BLANK: begin
          if (stop_i) begin
            state_q <= IDLE;
            row_q   <= 3'd0;
            blank_q <= 8'd0;
            busy_q  <= 1'b0;
          end else if (blank_q == BLANK_LAST) begin
            // selects held the outgoing row; 7 wraps to 0 naturally
            state_q <= DRIVE;
            row_q   <= row_q + 3'd1;
            blank_q <= 8'd0;
            en_q    <= 1'b1;
          end else begin
            blank_q <= blank_q + 8'd1;
          end
        end
`endif
        default: begin
          state_q <= IDLE;
          row_q   <= 3'd0;
          dwell_q <= 8'd0;
          en_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign select_a_o  = row_q[0];
  assign select_b_o  = row_q[1];
  assign select_c_o  = row_q[2];
  assign row_idx_o   = row_q;
  assign g1_en_o     = en_q;
  assign g2a_en_n_o  = ~en_q;
  assign g2b_en_n_o  = ~en_q;
  assign busy_o      = busy_q;
  assign scan_done_o = done_q;

endmodule

// File: doc/decoder_scan_seq.md
DECODER_SCAN_SEQ -- requirements
Module: decoder_scan_seq

Interface
REQ-001 Parameter DWELL_CYCLES, default 4: cycles each row stays selected; legal range 1..255.
REQ-002 Parameter BLANK_CYCLES, default 1: decoder-disabled cycles between rows when blanking is compiled in; legal range 1..255.
REQ-003 clk_i  input  1  single clock, rising-edge active.
REQ-004 rst_n_i  input  1  reset, asynchronous assert, active-low.
REQ-005 start_i  input  1  request one sweep of rows 0..7; sampled only in IDLE.
REQ-006 stop_i  input  1  abort the current sweep.
REQ-007 continuous_i  input  1  when 1 at the end of row 7, wrap to row 0 instead of ending.
REQ-008 select_a_o / select_b_o / select_c_o  output  1 each  row index bits 0/1/2 driving the downstream 3-to-8 decoder A/B/C inputs.
REQ-009 g1_en_o  output  1  active-high decoder enable.
REQ-010 g2a_en_n_o / g2b_en_n_o  output  1 each  active-low decoder enables.
REQ-011 row_idx_o  output  3  current row index, equal to {select_c_o, select_b_o, select_a_o}.
REQ-012 busy_o  output  1  high in DRIVE and BLANK.
REQ-013 scan_done_o  output  1  one-cycle pulse when row 7 completes.

Function
REQ-014 All outputs SHALL be registered; no combinational input-to-output path.
REQ-015 FSM states SHALL be IDLE, DRIVE and BLANK; BLANK is present only with blanking compiled in.
REQ-016 Idle output values: g1_en_o=0, g2a_en_n_o=1, g2b_en_n_o=1, selects=0, busy_o=0.
REQ-017 IDLE with start_i=1 and stop_i=0 SHALL enter DRIVE at row 0, with dwell counter=0 and the enables asserted in the next cycle.
REQ-018 In DRIVE, the block SHALL assert g1_en_o=1, g2a_en_n_o=0 and g2b_en_n_o=0, and the selects SHALL equal the row.
REQ-019 Each row SHALL be held for exactly DWELL_CYCLES cycles.
REQ-020 At the end of a non-final row, the row SHALL increment by 1: directly in DRIVE, or via BLANK when blanking is compiled in.
REQ-021 At the end of row 7 with continuous_i=1, the row SHALL wrap to 0: via BLANK when blanking is compiled in, otherwise directly.
REQ-022 At the end of row 7 with continuous_i=0, the FSM SHALL go to IDLE with no BLANK.
REQ-023 scan_done_o SHALL pulse high for one cycle, in the cycle after the last DRIVE cycle of row 7.
REQ-024 stop_i=1 in DRIVE or BLANK SHALL force idle outputs in the next cycle; scan_done_o stays 0.
REQ-025 stop_i SHALL take priority over start_i and over row completion in the same cycle.
REQ-026 start_i while busy_o=1 SHALL be ignored.
REQ-027 Dwell and blank counters SHALL be 8 bits wide and saturate-free, because the legal range guarantees no overflow.

Reset
REQ-028 rst_n_i=0 SHALL immediately force IDLE, the idle output values, scan_done_o=0 and cleared counters, including mid-sweep.
REQ-029 After reset release, no sweep SHALL start without a new start_i.

Configuration
REQ-030 Macro BLANKING_EN defined: BLANK state present; after each DRIVE row except a final row 7, the enables SHALL deassert for BLANK_CYCLES cycles with the selects holding the outgoing row, then DRIVE the next row.
REQ-031 Macro BLANKING_EN undefined: BLANK state and blank counter absent; rows SHALL be back-to-back and BLANK_CYCLES SHALL be ignored.

Verification (DWELL_CYCLES=4, BLANK_CYCLES=1)
REQ-032 Reset asserted mid-run, then released -> idle output values immediately; no activity until start_i.
REQ-033 Macro off, 1-cycle start_i, continuous_i=0 -> rows 0..7 for 4 cycles each; busy_o high for 32 cycles; one scan_done_o pulse; return to idle.
REQ-034 Macro off, continuous_i=1 -> row 7 is followed directly by row 0; scan_done_o pulses every 32 cycles.
REQ-035 stop_i in the 2nd cycle of row 3 -> idle outputs in the next cycle, busy_o=0, no scan_done_o; start_i and stop_i together in IDLE -> stays IDLE.
REQ-036 BLANKING_EN defined, one-shot -> 1 disabled cycle between rows with the selects holding the old row; busy_o high for 39 cycles; one scan_done_o pulse.
REQ-037 BLANKING_EN defined, continuous_i=1 -> 1 blank cycle between row 7 and row 0; scan_done_o period of 40 cycles.
